// File: rtl/dram_line_memory_pkg.sv
// Shared types and defaults for the DRAM line-memory stage.
package dram_line_memory_pkg;

    localparam int unsigned DRAM_LATENCY = 10;
    localparam int unsigned DRAM_ADDR_W  = 10;
    localparam int unsigned DRAM_LINE_W  = 256;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2,
        StHold = 2'd3
    } dram_state_e;

    // Latency counter must hold LATENCY-1 down to 0 without wrapping.
    function automatic int unsigned dram_cnt_width(input int unsigned latency);
        return (latency < 2) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/dram_line_memory_if.sv
// Request/response bundle between the cache controller (master) and main memory (slave).
interface dram_line_memory_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LINE_W = 256
);
    logic              dram_cs;
    logic              dram_we;
    logic [ADDR_W-1:0] dram_addr;
    logic [LINE_W-1:0] dram_wdata;
    logic [LINE_W-1:0] dram_rdata;
    logic              dram_ack;
    logic              dram_busy;

    modport master (
        output dram_cs, dram_we, dram_addr, dram_wdata,
        input  dram_rdata, dram_ack, dram_busy
    );

    modport slave (
        input  dram_cs, dram_we, dram_addr, dram_wdata,
        output dram_rdata, dram_ack, dram_busy
    );
endinterface

// File: rtl/dram_line_memory_array.sv
// Line storage: synchronous write, combinational read, no reset.
module dram_line_array #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);

    logic [LINE_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dram_line_memory.sv
// Fixed-latency whole-line main memory with one-cycle ack pulse.
// Optional access counters enabled by defining DRAM_ACCESS_COUNT_EN.
module dram_line_memory
    import dram_line_memory_pkg::*;
#(
    parameter int unsigned LATENCY = DRAM_LATENCY,
    parameter int unsigned ADDR_W  = DRAM_ADDR_W,
    parameter int unsigned LINE_W  = DRAM_LINE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    dram_line_memory_if.slave  bus
`ifdef DRAM_ACCESS_COUNT_EN
    ,
    output logic [31:0]        o_rd_count,
    output logic [31:0]        o_wr_count
`endif
);

    localparam int unsigned     CNT_W    = dram_cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    dram_state_e       r_state;
    dram_state_e       w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_rdata;
    logic [LINE_W-1:0] w_arr_rdata;
    logic              w_accept;
    logic              w_load_rdata;
    logic              w_arr_we;
    logic              w_ack;
    logic              w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.dram_cs) w_state_next = StBusy;
            StBusy:  if (r_cnt == '0) w_state_next = StDone;
            StDone:  w_state_next = StHold;
            StHold:  if (!bus.dram_cs) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Read data is captured on entry to DONE so it is already valid during the ack cycle.
    always_comb begin
        w_accept     = (r_state == StIdle) && bus.dram_cs;
        w_load_rdata = (r_state == StBusy) && (r_cnt == '0) && !r_we;
        w_arr_we     = (r_state == StDone) && r_we;
        w_ack        = (r_state == StDone);
        w_busy       = (r_state != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_we    <= bus.dram_we;
                r_addr  <= bus.dram_addr;
                r_wdata <= bus.dram_wdata;
            end else if ((r_state == StBusy) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_load_rdata) begin
                r_rdata <= w_arr_rdata;
            end
        end
    end

    dram_line_array #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign bus.dram_rdata = r_rdata;
    assign bus.dram_ack   = w_ack;
    assign bus.dram_busy  = w_busy;

`ifdef DRAM_ACCESS_COUNT_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_ack) begin
            if (r_we) begin
                r_wr_count <= r_wr_count + 32'd1;
            end else begin
                r_rd_count <= r_rd_count + 32'd1;
            end
        end
    end

    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_dram_line_memory.sv
// Scoreboard bench for dram_line_memory: a LATENCY=10 instance and a LATENCY=1 instance.
module tb_dram_line_memory;

    localparam int unsigned AW = 10;
    localparam int unsigned LW = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_line_memory_if #(.ADDR_W(AW), .LINE_W(LW)) bus0 ();
    dram_line_memory_if #(.ADDR_W(AW), .LINE_W(LW)) bus1 ();

    logic [1:0]    cs_v;
    logic [1:0]    we_v;
    logic [AW-1:0] addr_v  [2];
    logic [LW-1:0] wdata_v [2];
    logic [1:0]    ack_w;
    logic [1:0]    busy_w;
    logic [LW-1:0] rdata_w [2];

    assign bus0.dram_cs    = cs_v[0];
    assign bus0.dram_we    = we_v[0];
    assign bus0.dram_addr  = addr_v[0];
    assign bus0.dram_wdata = wdata_v[0];
    assign bus1.dram_cs    = cs_v[1];
    assign bus1.dram_we    = we_v[1];
    assign bus1.dram_addr  = addr_v[1];
    assign bus1.dram_wdata = wdata_v[1];
    assign ack_w      = {bus1.dram_ack, bus0.dram_ack};
    assign busy_w     = {bus1.dram_busy, bus0.dram_busy};
    assign rdata_w[0] = bus0.dram_rdata;
    assign rdata_w[1] = bus1.dram_rdata;

`ifdef DRAM_ACCESS_COUNT_EN
    logic [31:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;
`endif

    dram_line_memory #(.LATENCY(10), .ADDR_W(AW), .LINE_W(LW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
`ifdef DRAM_ACCESS_COUNT_EN
        ,
        .o_rd_count (rd_cnt0),
        .o_wr_count (wr_cnt0)
`endif
    );

    dram_line_memory #(.LATENCY(1), .ADDR_W(AW), .LINE_W(LW)) u_dut_lat1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef DRAM_ACCESS_COUNT_EN
        ,
        .o_rd_count (rd_cnt1),
        .o_wr_count (wr_cnt1)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [LW-1:0] model_mem [int];
    logic [LW-1:0] exp_q [$];

    // One request: drives at a negedge, sampled at the next posedge, then tracks ack.
    // hold: cycles cs stays high after ack; alt_addr >= 0 perturbs inputs during BUSY.
    task automatic req(input int sel, input bit we, input logic [AW-1:0] a,
                       input logic [LW-1:0] d, input int hold, input int exp_lat,
                       input int alt_addr, input string name);
        int k;
        int key;
        logic [LW-1:0] exp;
        key = sel * 4096 + int'(a);
        @(negedge clk);
        cs_v[sel] = 1'b1; we_v[sel] = we; addr_v[sel] = a; wdata_v[sel] = d;
        if (!we) exp_q.push_back(model_mem[key]);
        @(posedge clk);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack_w[sel]) break;
            if (k == 1 && alt_addr >= 0) begin
                addr_v[sel] = alt_addr[AW-1:0]; wdata_v[sel] = ~d; we_v[sel] = ~we;
            end
        end
        total++;
        if (k !== exp_lat) begin
            bad++; $display("FAIL %s latency: got %0d cycles, expected %0d", name, k, exp_lat);
        end
        total++;
        if (busy_w[sel] !== 1'b1) begin
            bad++; $display("FAIL %s busy_at_ack: got %b, expected 1", name, busy_w[sel]);
        end
        if (!we) begin
            exp = exp_q.pop_front();
            total++;
            if (rdata_w[sel] !== exp) begin
                bad++; $display("FAIL %s rdata: got %h, expected %h", name, rdata_w[sel], exp);
            end
        end else begin
            model_mem[key] = d;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            total++;
            if (ack_w[sel] !== 1'b0 || busy_w[sel] !== 1'b1) begin
                bad++;
                $display("FAIL %s stale_cs: ack=%b busy=%b, expected ack=0 busy=1",
                         name, ack_w[sel], busy_w[sel]);
            end
        end
        cs_v[sel] = 1'b0;
        @(negedge clk);
        total++;
        if (ack_w[sel] !== 1'b0) begin
            bad++; $display("FAIL %s ack_single: got %b, expected 0", name, ack_w[sel]);
        end
        @(negedge clk);
        total++;
        if (busy_w[sel] !== 1'b0) begin
            bad++; $display("FAIL %s busy_release: got %b, expected 0", name, busy_w[sel]);
        end
    endtask

    task automatic test_reset();
        logic [LW-1:0] pat;
        int k;
        int acks;
        pat = {8{32'hDEAD_BEEF}};
        @(negedge clk);
        total++;
        if (ack_w !== 2'b00 || busy_w !== 2'b00) begin
            bad++; $display("FAIL reset_ctrl: ack=%b busy=%b, expected 00/00", ack_w, busy_w);
        end
        total++;
        if (rdata_w[0] !== '0 || rdata_w[1] !== '0) begin
            bad++; $display("FAIL reset_rdata: got %h / %h, expected 0", rdata_w[0], rdata_w[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cs_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 10'd5; wdata_v[0] = pat;
        @(posedge clk);
        repeat (4) @(negedge clk);
        cs_v[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (ack_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || rdata_w[0] !== '0) begin
            bad++;
            $display("FAIL reset_midbusy: ack=%b busy=%b rdata=%h, expected all 0",
                     ack_w[0], busy_w[0], rdata_w[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (15) begin
            @(negedge clk);
            if (ack_w[0]) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++; $display("FAIL reset_abort_ack: got %0d acks, expected 0", acks);
        end
        @(negedge clk);
        cs_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 10'd5;
        @(posedge clk);
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack_w[0]) break;
        end
        total++;
        if (k !== 10) begin
            bad++; $display("FAIL reset_read_latency: got %0d, expected 10", k);
        end
        total++;
        if (rdata_w[0] === pat) begin
            bad++; $display("FAIL reset_no_commit: got %h, expected anything else", rdata_w[0]);
        end
        cs_v[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read();
        req(0, 1'b1, 10'd3, {32{8'hA5}}, 2, 10, -1, "wr3");
        req(0, 1'b0, 10'd3, '0, 0, 10, -1, "rd3");
        for (int i = 0; i < 3; i++) begin
            req(0, 1'b1, AW'(100 + i), {8{$urandom()}}, 0, 10, -1, "wr_rand");
        end
        for (int i = 2; i >= 0; i--) begin
            req(0, 1'b0, AW'(100 + i), '0, 0, 10, -1, "rd_rand");
        end
    endtask

    task automatic test_stale_cs();
        req(0, 1'b1, 10'd40, {4{64'h0123_4567_89AB_CDEF}}, 5, 10, -1, "stale_wr");
        req(0, 1'b0, 10'd40, '0, 0, 10, -1, "stale_reraise_rd");
    endtask

    task automatic test_input_change();
        req(0, 1'b1, 10'd7, {16{16'h7777}}, 0, 10, -1, "chg_wr7");
        req(0, 1'b1, 10'd9, {16{16'h9999}}, 0, 10, -1, "chg_wr9");
        req(0, 1'b0, 10'd7, '0, 0, 10, 9, "chg_rd7");
        req(0, 1'b0, 10'd9, '0, 0, 10, -1, "chg_rd9");
    endtask

    task automatic test_latency1();
        req(1, 1'b1, 10'd0, {8{32'hC0FF_EE11}}, 0, 1, -1, "lat1_wr0");
        req(1, 1'b0, 10'd0, '0, 0, 1, -1, "lat1_rd0");
        req(1, 1'b1, 10'd0, {8{32'h1234_5678}}, 0, 1, -1, "lat1_wr0b");
        req(1, 1'b0, 10'd0, '0, 0, 1, -1, "lat1_rd0b");
    endtask

`ifdef DRAM_ACCESS_COUNT_EN
    task automatic test_counts();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        total++;
        if (rd_cnt0 !== 32'd0 || wr_cnt0 !== 32'd0) begin
            bad++; $display("FAIL count_reset0: rd=%0d wr=%0d, expected 0/0", rd_cnt0, wr_cnt0);
        end
        for (int i = 0; i < 3; i++) begin
            req(0, 1'b1, AW'(20 + i), {8{$urandom()}}, 0, 10, -1, "cnt_wr");
        end
        for (int i = 0; i < 2; i++) begin
            req(0, 1'b0, AW'(20 + i), '0, 0, 10, -1, "cnt_rd");
        end
        total++;
        if (rd_cnt0 !== 32'd2 || wr_cnt0 !== 32'd3) begin
            bad++; $display("FAIL count_value: rd=%0d wr=%0d, expected 2/3", rd_cnt0, wr_cnt0);
        end
        @(negedge clk); rst_n = 1'b0;
        #1;
        total++;
        if (rd_cnt0 !== 32'd0 || wr_cnt0 !== 32'd0) begin
            bad++; $display("FAIL count_reset1: rd=%0d wr=%0d, expected 0/0", rd_cnt0, wr_cnt0);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask
`endif

    initial begin
        cs_v = 2'b00;
        we_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_v[i]  = '0;
            wdata_v[i] = '0;
        end
        test_reset();
        test_write_read();
        test_stale_cs();
        test_input_change();
        test_latency1();
`ifdef DRAM_ACCESS_COUNT_EN
        test_counts();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
